// File: rtl/fft_stage_sequencer.sv
// In-place 16-point radix-2 DIT FFT sequencer driving an external butterfly and registered twiddle LUT.
// Optional macro FFT_SCALE_EN: halve every written-back butterfly result (1/16 overall scaling).
module fft_stage_sequencer #(
  parameter int DATA_W     = 16,
  parameter int BF_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_data_r,
  input  logic [DATA_W-1:0] i_data_c,
  output logic [DATA_W-1:0] o_bf_ra,
  output logic [DATA_W-1:0] o_bf_ca,
  output logic [DATA_W-1:0] o_bf_rb,
  output logic [DATA_W-1:0] o_bf_cb,
  output logic [3:0]        o_twiddle_num,
  input  logic [DATA_W-1:0] i_bf_ra,
  input  logic [DATA_W-1:0] i_bf_ca,
  input  logic [DATA_W-1:0] i_bf_rb,
  input  logic [DATA_W-1:0] i_bf_cb,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_r,
  output logic [DATA_W-1:0] o_data_c,
  output logic              o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [2:0]        r_k;
  logic [1:0]        r_stage;
  logic [2:0]        r_drain;
  logic              r_valid;
  logic [DATA_W-1:0] r_data_r, r_data_c;
  logic [DATA_W-1:0] r_mem_r [16];
  logic [DATA_W-1:0] r_mem_c [16];
  logic              r_pipe_v [BF_LATENCY];
  logic [3:0]        r_pipe_a [BF_LATENCY];
  logic [3:0]        r_pipe_b [BF_LATENCY];

  logic              w_issue, w_in_ready, w_in_xfer, w_wb;
  logic [3:0]        w_a, w_b, w_wb_a, w_wb_b;
  logic [DATA_W-1:0] w_wr_ra, w_wr_ca, w_wr_rb, w_wr_cb;

  function automatic logic [3:0] f_bitrev(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [3:0] f_mask(input logic [1:0] s);
    return (4'd1 << s) - 4'd1;
  endfunction

  // Lower operand of butterfly k in stage s: group base plus position inside the group.
  function automatic logic [3:0] f_addr_a(input logic [1:0] s, input logic [2:0] k);
    logic [3:0] kk;
    kk = {1'b0, k};
    return (((kk >> s) << s) << 1) | (kk & f_mask(s));
  endfunction

  function automatic logic [3:0] f_twiddle(input logic [1:0] s, input logic [2:0] k);
    return ({1'b0, k} & f_mask(s)) << (2'd3 - s);
  endfunction

  assign w_issue    = (r_state == S_ISSUE);
  assign w_a        = f_addr_a(r_stage, r_k);
  assign w_b        = w_a | (4'd1 << r_stage);
  // NOTE: ready is decoded from state and masked by rst so it is low during reset yet high on the first cycle after release.
  assign w_in_ready = !rst && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_in_xfer  = i_valid && w_in_ready;

  assign w_wb   = r_pipe_v[BF_LATENCY-1];
  assign w_wb_a = r_pipe_a[BF_LATENCY-1];
  assign w_wb_b = r_pipe_b[BF_LATENCY-1];

`ifdef FFT_SCALE_EN
  assign w_wr_ra = DATA_W'($signed(i_bf_ra) >>> 1);
  assign w_wr_ca = DATA_W'($signed(i_bf_ca) >>> 1);
  assign w_wr_rb = DATA_W'($signed(i_bf_rb) >>> 1);
  assign w_wr_cb = DATA_W'($signed(i_bf_cb) >>> 1);
`else
  assign w_wr_ra = i_bf_ra;
  assign w_wr_ca = i_bf_ca;
  assign w_wr_rb = i_bf_rb;
  assign w_wr_cb = i_bf_cb;
`endif

  // Operands are read combinationally so the first issue of a stage sees the last write-back of the previous one.
  assign o_bf_ra       = w_issue ? r_mem_r[w_a] : '0;
  assign o_bf_ca       = w_issue ? r_mem_c[w_a] : '0;
  assign o_bf_rb       = w_issue ? r_mem_r[w_b] : '0;
  assign o_bf_cb       = w_issue ? r_mem_c[w_b] : '0;
  assign o_twiddle_num = (w_issue && r_k != 3'd7) ? f_twiddle(r_stage, r_k + 3'd1) : 4'd0;
  assign o_in_ready    = w_in_ready;
  assign o_valid       = r_valid;
  assign o_data_r      = r_data_r;
  assign o_data_c      = r_data_c;
  assign o_busy        = (r_state != S_IDLE);

  // NOTE: the sample memory has no reset; stale contents are always overwritten by the next load.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_mem_r[f_bitrev(r_cnt)] <= i_data_r;
      r_mem_c[f_bitrev(r_cnt)] <= i_data_c;
    end
    if (w_wb) begin
      r_mem_r[w_wb_a] <= w_wr_ra;
      r_mem_c[w_wb_a] <= w_wr_ca;
      r_mem_r[w_wb_b] <= w_wr_rb;
      r_mem_c[w_wb_b] <= w_wr_cb;
    end
  end

  // Address delay line matching the butterfly latency; clearing it on reset drops in-flight results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        r_pipe_v[i] <= 1'b0;
        r_pipe_a[i] <= '0;
        r_pipe_b[i] <= '0;
      end
    end else begin
      r_pipe_v[0] <= w_issue;
      r_pipe_a[0] <= w_a;
      r_pipe_b[0] <= w_b;
      for (int i = 1; i < BF_LATENCY; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_a[i] <= r_pipe_a[i-1];
        r_pipe_b[i] <= r_pipe_b[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_k      <= '0;
      r_stage  <= '0;
      r_drain  <= '0;
      r_valid  <= 1'b0;
      r_data_r <= '0;
      r_data_c <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_in_xfer) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= S_ISSUE;
              r_k     <= '0;
              r_stage <= '0;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_ISSUE: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          if (r_drain == 3'(BF_LATENCY - 1)) begin
            r_drain <= '0;
            if (r_stage == 2'd3) begin
              r_state <= S_OUT;
              r_cnt   <= '0;
            end else begin
              r_stage <= r_stage + 2'd1;
              r_state <= S_ISSUE;
            end
          end else begin
            r_drain <= r_drain + 3'd1;
          end
        end
        S_OUT: begin
          if (!r_valid) begin
            r_valid  <= 1'b1;
            r_data_r <= r_mem_r[r_cnt];
            r_data_c <= r_mem_c[r_cnt];
          end else if (i_ready) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_data_r <= r_mem_r[r_cnt + 4'd1];
              r_data_c <= r_mem_c[r_cnt + 4'd1];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
